// File: rtl/hex_keypad_scanner.sv
// Purpose: scans a 4x4 active-low hex keypad, debounces it and reports one 4-bit key code per press.
// Latency: key_valid one cycle after the DEBOUNCE_CNT-th confirming sample tick; rows add 2 sync cycles.
// Backpressure: none; key_valid is a one-cycle pulse and key_code holds until the next accepted key.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   row[3:0]  keypad rows, active-low, asynchronous (synchronised here)
//   col[3:0]  keypad columns, active-low, exactly one low at a time
//   key_code  last accepted key = 4*row_idx + col_idx
//   key_valid one-cycle pulse when a new key is accepted
//   key_held  high from accept until the release is accepted
module hex_keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD
    } state_t;

    // Row synchroniser; idle level is all-ones because of the board pull-ups.
    logic [3:0] row_meta;
    logic [3:0] rs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            rs       <= 4'hF;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    // Column dwell divider; rows are sampled on its last count, which leaves
    // enough cycles after a column change for the new rows to pass the synchroniser.
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Lowest-index pressed row wins.
    logic       any_press;
    logic [1:0] low_row;

    always_comb begin
        any_press = (rs != 4'hF);
        low_row   = 2'd3;
        if (!rs[0]) begin
            low_row = 2'd0;
        end else if (!rs[1]) begin
            low_row = 2'd1;
        end else if (!rs[2]) begin
            low_row = 2'd2;
        end
    end

    state_t           state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       cand_row_q, cand_row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       code_d;
    logic             valid_d;
    logic             held_d;

    assign col = ~(4'b0001 << col_idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SCAN;
            col_idx_q  <= 2'd0;
            cand_row_q <= 2'd0;
            cnt_q      <= '0;
            key_code   <= 4'd0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            cand_row_q <= cand_row_d;
            cnt_q      <= cnt_d;
            key_code   <= code_d;
            key_valid  <= valid_d;
            key_held   <= held_d;
        end
    end

    // The column index is frozen outside SCAN, so col_idx_q doubles as the
    // candidate column while debouncing and holding.
    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        cand_row_d = cand_row_q;
        cnt_d      = cnt_q;
        code_d     = key_code;
        valid_d    = 1'b0;
        held_d     = key_held;
        cnt_inc    = cnt_q + 1'b1;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (!any_press) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        cand_row_d = low_row;
                        cnt_d      = '0;
                        state_d    = DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    // A release, or a lower row taking over, aborts the candidate.
                    if (any_press && (low_row == cand_row_q)) begin
                        if (cnt_inc == CNT_DONE) begin
                            code_d  = {cand_row_q, col_idx_q};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                HELD: begin
                    // Only the held row matters; any re-press restarts the release count.
                    if (rs[cand_row_q]) begin
                        if (cnt_inc == CNT_DONE) begin
                            held_d    = 1'b0;
                            cnt_d     = '0;
                            col_idx_d = col_idx_q + 2'd1;
                            state_d   = SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end
endmodule
